// File: rtl/trap_csrfile.sv
// trap_csrfile: machine-mode CSR file with trap entry/return, cycle and
// retired-instruction counters and a level-sensitive timer interrupt.
// Optional feature macro: CSR_MINSTRET_EN builds the minstret counter; when it
// is not defined, 0xB02 reads zero, ignores writes and instret is unused.
module trap_csrfile #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] HARTID    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_rd_ena,
    input  logic [11:0]     csr_rd_addr,
    output logic [XLEN-1:0] csr_rd_data,
    input  logic            csr_wr_ena,
    input  logic [11:0]     csr_wr_addr,
    input  logic [1:0]      csr_wr_op,
    input  logic [XLEN-1:0] csr_wr_data,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            instret,
    input  logic            timer_irq,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending,
    output logic            csr_illegal
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NONE  = 2'b11;

    // Read-view slots; slot 0 is the constant-zero view.
    localparam logic [3:0] V_ZERO     = 4'd0;
    localparam logic [3:0] V_MSTATUS  = 4'd1;
    localparam logic [3:0] V_MISA     = 4'd2;
    localparam logic [3:0] V_MIE      = 4'd3;
    localparam logic [3:0] V_MTVEC    = 4'd4;
    localparam logic [3:0] V_MSCRATCH = 4'd5;
    localparam logic [3:0] V_MEPC     = 4'd6;
    localparam logic [3:0] V_MCAUSE   = 4'd7;
    localparam logic [3:0] V_MIP      = 4'd8;
    localparam logic [3:0] V_MCYCLE   = 4'd9;
    localparam logic [3:0] V_MINSTRET = 4'd10;
    localparam logic [3:0] V_MHARTID  = 4'd11;

    // misa: MXL in the top two bits, 'I' base ISA bit.
    localparam logic [1:0]      MXL      = (XLEN == 32) ? 2'd1 : ((XLEN == 64) ? 2'd2 : 2'd3);
    localparam logic [XLEN-1:0] MISA_VAL = {MXL, {(XLEN-11){1'b0}}, 9'h100};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};

    // Map an address onto its read-view slot.
    function automatic logic [3:0] csr_idx(input logic [11:0] addr);
        case (addr)
            A_MSTATUS:  csr_idx = V_MSTATUS;
            A_MISA:     csr_idx = V_MISA;
            A_MIE:      csr_idx = V_MIE;
            A_MTVEC:    csr_idx = V_MTVEC;
            A_MSCRATCH: csr_idx = V_MSCRATCH;
            A_MEPC:     csr_idx = V_MEPC;
            A_MCAUSE:   csr_idx = V_MCAUSE;
            A_MIP:      csr_idx = V_MIP;
            A_MCYCLE:   csr_idx = V_MCYCLE;
            A_MINSTRET: csr_idx = V_MINSTRET;
            A_MHARTID:  csr_idx = V_MHARTID;
            default:    csr_idx = V_ZERO;
        endcase
    endfunction

    function automatic logic csr_impl(input logic [11:0] addr);
        case (addr)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MIP, A_MCYCLE, A_MINSTRET, A_MVENDORID, A_MARCHID, A_MIMPID,
            A_MHARTID: csr_impl = 1'b1;
            default:   csr_impl = 1'b0;
        endcase
    endfunction

    // minstret stays "writable" even when not built: its writes vanish quietly.
    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MINSTRET: csr_writable = 1'b1;
            default:              csr_writable = 1'b0;
        endcase
    endfunction

    logic            mst_mie_q, mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_rd;

    logic [XLEN-1:0] csr_view [16];
    logic [XLEN-1:0] wr_old;
    logic [XLEN-1:0] wr_val;
    logic            wr_go;
    logic            wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
    logic            wr_mepc, wr_mcause, wr_mcycle, wr_minstret;
    logic [XLEN-1:0] mtvec_base;
    logic            unused_bits;

`ifdef CSR_MINSTRET_EN
    logic [XLEN-1:0] minstret_q, minstret_d;

    // Retired-instruction counter; a CSR write in the same cycle wins.
    always_comb begin
        minstret_d = minstret_q + {{(XLEN-1){1'b0}}, instret};
        if (wr_minstret) begin
            minstret_d = wr_val;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret_q <= '0;
        end else begin
            minstret_q <= minstret_d;
        end
    end

    assign minstret_rd = minstret_q;
    assign unused_bits = ^{trap_pc[1:0]};
`else
    assign minstret_rd = '0;
    assign unused_bits = ^{trap_pc[1:0], instret, wr_minstret};
`endif

    // Build the architectural read value of every implemented CSR.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            csr_view[i] = '0;
        end
        csr_view[V_MSTATUS][3]     = mst_mie_q;
        csr_view[V_MSTATUS][7]     = mst_mpie_q;
        csr_view[V_MSTATUS][12:11] = 2'b11;
        csr_view[V_MISA]           = MISA_VAL;
        csr_view[V_MIE][7]         = mie_mtie_q;
        csr_view[V_MTVEC]          = mtvec_q;
        csr_view[V_MSCRATCH]       = mscratch_q;
        csr_view[V_MEPC]           = mepc_q;
        csr_view[V_MCAUSE]         = mcause_q;
        csr_view[V_MIP][7]         = timer_irq;
        csr_view[V_MCYCLE]         = mcycle_q;
        csr_view[V_MINSTRET]       = minstret_rd;
        csr_view[V_MHARTID]        = HARTID;
    end

    // Read-modify-write value and per-register write strobes.
    always_comb begin
        wr_old = csr_view[csr_idx(csr_wr_addr)];
        case (csr_wr_op)
            OP_WRITE: wr_val = csr_wr_data;
            OP_SET:   wr_val = wr_old | csr_wr_data;
            OP_CLEAR: wr_val = wr_old & ~csr_wr_data;
            default:  wr_val = wr_old;
        endcase
        wr_go       = csr_wr_ena && (csr_wr_op != OP_NONE) && csr_writable(csr_wr_addr);
        wr_mstatus  = wr_go && (csr_wr_addr == A_MSTATUS);
        wr_mie      = wr_go && (csr_wr_addr == A_MIE);
        wr_mtvec    = wr_go && (csr_wr_addr == A_MTVEC);
        wr_mscratch = wr_go && (csr_wr_addr == A_MSCRATCH);
        wr_mepc     = wr_go && (csr_wr_addr == A_MEPC);
        wr_mcause   = wr_go && (csr_wr_addr == A_MCAUSE);
        wr_mcycle   = wr_go && (csr_wr_addr == A_MCYCLE);
        wr_minstret = wr_go && (csr_wr_addr == A_MINSTRET);
    end

    // Next state: CSR write first, then mret, then trap so the later one wins.
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (wr_mstatus) begin
            mst_mie_d  = wr_val[3];
            mst_mpie_d = wr_val[7];
        end
        if (wr_mepc) begin
            mepc_d = {wr_val[XLEN-1:2], 2'b00};
        end
        if (wr_mcause) begin
            mcause_d = wr_val;
        end
        if (mret_valid) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
        if (trap_valid) begin
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mepc_d     = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d   = trap_cause;
        end
        mie_mtie_d = wr_mie ? wr_val[7] : mie_mtie_q;
        // Only direct (00) and vectored (01) modes exist; anything else is direct.
        mtvec_d    = wr_mtvec ? {wr_val[XLEN-1:2], (wr_val[1:0] == 2'b01) ? 2'b01 : 2'b00}
                              : mtvec_q;
        mscratch_d = wr_mscratch ? wr_val : mscratch_q;
        mcycle_d   = wr_mcycle ? wr_val : (mcycle_q + ONE);
    end

    // State registers; reset overrides trap, mret and CSR writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_mtie_q <= mie_mtie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
    // Vectored entry only for interrupts (cause MSB set); offset is 4*code.
    assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_cause[XLEN-1])
                         ? (mtvec_base + {trap_cause[XLEN-3:0], 2'b00})
                         : mtvec_base;
    assign mepc_o      = mepc_q;
    assign irq_pending = mst_mie_q & mie_mtie_q & timer_irq;
    assign csr_rd_data = (csr_rd_ena && !rst) ? csr_view[csr_idx(csr_rd_addr)] : '0;
    assign csr_illegal = (csr_rd_ena && !csr_impl(csr_rd_addr))
                      || (csr_wr_ena && !csr_writable(csr_wr_addr));

endmodule

// File: tb/tb_trap_csrfile.sv
// Testbench for trap_csrfile: directed table, hand sequences for trap/mret and
// counter corners, then random traffic against an address-indexed CSR model.
module tb_trap_csrfile;
    localparam int          XLEN      = 64;
    localparam logic [63:0] MTVEC_RST = 64'h0000_0000_0000_0100;
    localparam logic [63:0] HARTID    = 64'h0000_0000_0000_0003;
`ifdef CSR_MINSTRET_EN
    localparam bit MINSTRET_ON = 1'b1;
`else
    localparam bit MINSTRET_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_rd_ena;
    logic [11:0] csr_rd_addr;
    logic [63:0] csr_rd_data;
    logic        csr_wr_ena;
    logic [11:0] csr_wr_addr;
    logic [1:0]  csr_wr_op;
    logic [63:0] csr_wr_data;
    logic        trap_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_pc;
    logic        mret_valid;
    logic        instret;
    logic        timer_irq;
    logic [63:0] trap_vector;
    logic [63:0] mepc_o;
    logic        irq_pending;
    logic        csr_illegal;

    int errors = 0;
    int checks = 0;

    trap_csrfile #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST), .HARTID(HARTID)) dut (
        .clk(clk), .rst(rst),
        .csr_rd_ena(csr_rd_ena), .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
        .csr_wr_ena(csr_wr_ena), .csr_wr_addr(csr_wr_addr), .csr_wr_op(csr_wr_op),
        .csr_wr_data(csr_wr_data),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .instret(instret), .timer_irq(timer_irq),
        .trap_vector(trap_vector), .mepc_o(mepc_o), .irq_pending(irq_pending),
        .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; csr_rd_ena = 1'b0; csr_rd_addr = '0;
        csr_wr_ena = 1'b0; csr_wr_addr = '0; csr_wr_op = 2'b11; csr_wr_data = '0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0;
        mret_valid = 1'b0; instret = 1'b0; timer_irq = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [63:0] exp);
        csr_rd_ena = 1'b1; csr_rd_addr = addr;
        #1;
        check(name, csr_rd_data, exp);
        csr_rd_ena = 1'b0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] data);
        csr_wr_ena = 1'b1; csr_wr_op = op; csr_wr_addr = addr; csr_wr_data = data;
        tick();
        csr_wr_ena = 1'b0; csr_wr_op = 2'b11;
    endtask

    // ---------------- reference model: address-indexed CSR storage ----------
    logic [63:0] mr [0:4095];

    task automatic m_reset();
        for (int i = 0; i < 4096; i++) mr[i] = '0;
        mr[12'h305] = MTVEC_RST;
    endtask

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h344, 12'hB00, 12'hB02, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02};
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a, input logic t);
        case (a)
            12'h300: return mr[a] | 64'h1800;
            12'h344: return t ? 64'h80 : 64'h0;
            12'hF14: return HARTID;
            12'hB02: return MINSTRET_ON ? mr[a] : 64'h0;
            default: return m_impl(a) ? mr[a] : 64'h0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_step();
        logic [63:0] old_ms, cyc, ins, old, nv;
        if (rst) begin
            m_reset();
            return;
        end
        old_ms = mr[12'h300];
        cyc = mr[12'hB00] + 64'd1;
        ins = mr[12'hB02] + (instret ? 64'd1 : 64'd0);
        if (csr_wr_ena && csr_wr_op != 2'b11 && m_writable(csr_wr_addr)) begin
            old = m_read(csr_wr_addr, timer_irq);
            nv = (csr_wr_op == 2'b00) ? csr_wr_data :
                 (csr_wr_op == 2'b01) ? (old | csr_wr_data) : (old & ~csr_wr_data);
            case (csr_wr_addr)
                12'h300: mr[12'h300] = nv & 64'h88;
                12'h304: mr[12'h304] = nv & 64'h80;
                12'h305: mr[12'h305] = (nv & ~64'h3) | ((nv[1:0] == 2'b01) ? 64'h1 : 64'h0);
                12'h340: mr[12'h340] = nv;
                12'h341: mr[12'h341] = nv & ~64'h3;
                12'h342: mr[12'h342] = nv;
                12'hB00: cyc = nv;
                12'hB02: ins = nv;
                default: ;
            endcase
        end
        mr[12'hB00] = cyc;
        if (MINSTRET_ON) mr[12'hB02] = ins;
        if (mret_valid) mr[12'h300] = (old_ms[7] ? 64'h8 : 64'h0) | 64'h80;
        if (trap_valid) begin
            mr[12'h300] = old_ms[3] ? 64'h80 : 64'h0;
            mr[12'h341] = trap_pc & ~64'h3;
            mr[12'h342] = trap_cause;
        end
    endtask

    function automatic logic [63:0] m_vector(input logic [63:0] cause);
        logic [63:0] base;
        base = mr[12'h305] & ~64'h3;
        if (mr[12'h305][1:0] == 2'b01 && cause[63])
            return base + ((cause & 64'h7FFF_FFFF_FFFF_FFFF) << 2);
        return base;
    endfunction

    // ---------------- directed table ----------------------------------------
    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [63:0] data;
        logic        exp_ill;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    logic [11:0] addr_pool [15];

    initial begin
        idle();

        // Reset, then ten idle cycles.
        rst = 1'b1; csr_rd_ena = 1'b1; csr_rd_addr = 12'h305;
        tick(); tick();
        check("rst_rd_zero", csr_rd_data, 64'h0);
        check("rst_mepc", mepc_o, 64'h0);
        rst = 1'b0; csr_rd_ena = 1'b0;
        repeat (10) tick();
        rd_chk("idle_mcycle", 12'hB00, 64'd10);
        rd_chk("rst_mtvec", 12'h305, MTVEC_RST);
        rd_chk("rst_mstatus", 12'h300, 64'h1800);
        check("rst_irq", {63'b0, irq_pending}, 64'h0);
        $display("seq reset: mcycle/mtvec/mstatus checked");

        // Timer interrupt gating by MIE and MTIE.
        timer_irq = 1'b1;
        wr(2'b01, 12'h300, 64'h8);
        check("irq_mtie_off", {63'b0, irq_pending}, 64'h0);
        wr(2'b01, 12'h304, 64'h80);
        check("irq_on", {63'b0, irq_pending}, 64'h1);
        wr(2'b10, 12'h300, 64'h8);
        check("irq_off", {63'b0, irq_pending}, 64'h0);
        timer_irq = 1'b0;
        $display("seq irq: gating checked");

        // Trap entry into vectored mtvec, then mret.
        wr(2'b01, 12'h300, 64'h8);
        wr(2'b00, 12'h305, 64'h1001);
        rd_chk("mtvec_vec", 12'h305, 64'h1001);
        trap_valid = 1'b1; trap_cause = 64'h8000_0000_0000_0007; trap_pc = 64'h8000_1002;
        #1;
        check("trap_vector", trap_vector, 64'h101C);
        tick();
        trap_valid = 1'b0;
        check("trap_mepc", mepc_o, 64'h8000_1000);
        rd_chk("trap_mstatus", 12'h300, 64'h1880);
        rd_chk("trap_mcause", 12'h342, 64'h8000_0000_0000_0007);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 64'h1888);
        $display("seq trap/mret: vector, mepc, mstatus checked");

        // Trap beats a same-cycle CSR write to mepc.
        trap_valid = 1'b1; trap_cause = 64'h2; trap_pc = 64'h4444_0006;
        wr(2'b00, 12'h341, 64'h1234);
        trap_valid = 1'b0;
        check("trap_vs_wr_mepc", mepc_o, 64'h4444_0004);
        $display("seq trap vs write: mepc checked");

        // mcycle wrap and read-only mhartid.
        wr(2'b00, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd_chk("mcycle_wrap", 12'hB00, 64'h0);
        csr_wr_ena = 1'b1; csr_wr_op = 2'b00; csr_wr_addr = 12'hF14; csr_wr_data = 64'h55;
        #1;
        check("hartid_wr_ill", {63'b0, csr_illegal}, 64'h1);
        tick();
        csr_wr_ena = 1'b0; csr_wr_op = 2'b11;
        rd_chk("hartid_keep", 12'hF14, HARTID);
        $display("seq mcycle wrap / mhartid checked");

        // Five retired instructions after reset.
        rst = 1'b1; tick(); rst = 1'b0;
        instret = 1'b1;
        repeat (5) tick();
        instret = 1'b0;
        rd_chk("minstret_5", 12'hB02, MINSTRET_ON ? 64'd5 : 64'd0);
        $display("seq minstret: count checked");

        // Read-side illegal flag.
        csr_rd_ena = 1'b1; csr_rd_addr = 12'h7C0; #1;
        check("rd_unimpl_ill", {63'b0, csr_illegal}, 64'h1);
        check("rd_unimpl_zero", csr_rd_data, 64'h0);
        csr_rd_addr = 12'h300; #1;
        check("rd_impl_ok", {63'b0, csr_illegal}, 64'h0);
        csr_rd_ena = 1'b0;

        // Table: write one CSR, then read it back.
        vecs[0]  = '{2'b00, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1888};
        vecs[1]  = '{2'b10, 12'h300, 64'h8,                   1'b0, 64'h1880};
        vecs[2]  = '{2'b00, 12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h80};
        vecs[3]  = '{2'b00, 12'h305, 64'h1003,                1'b0, 64'h1000};
        vecs[4]  = '{2'b00, 12'h305, 64'h2001,                1'b0, 64'h2001};
        vecs[5]  = '{2'b01, 12'h305, 64'h2,                   1'b0, 64'h2000};
        vecs[6]  = '{2'b00, 12'h340, 64'hDEAD_BEEF_1234_5678, 1'b0, 64'hDEAD_BEEF_1234_5678};
        vecs[7]  = '{2'b10, 12'h340, 64'hFFFF_0000_0000_0000, 1'b0, 64'h0000_BEEF_1234_5678};
        vecs[8]  = '{2'b00, 12'h341, 64'h1237,                1'b0, 64'h1234};
        vecs[9]  = '{2'b00, 12'h342, 64'h8000_0000_0000_0003, 1'b0, 64'h8000_0000_0000_0003};
        vecs[10] = '{2'b11, 12'h340, 64'h0,                   1'b0, 64'h0000_BEEF_1234_5678};
        vecs[11] = '{2'b00, 12'hF14, 64'h5,                   1'b1, HARTID};
        vecs[12] = '{2'b00, 12'hF11, 64'h7,                   1'b1, 64'h0};
        vecs[13] = '{2'b00, 12'h7C0, 64'h9,                   1'b1, 64'h0};
        vecs[14] = '{2'b00, 12'h344, 64'hFF,                  1'b1, 64'h0};
        vecs[15] = '{2'b00, 12'hB02, 64'h55,                  1'b0, MINSTRET_ON ? 64'h55 : 64'h0};
        for (int i = 0; i < 16; i++) begin
            csr_wr_ena = 1'b1; csr_wr_op = vecs[i].op;
            csr_wr_addr = vecs[i].addr; csr_wr_data = vecs[i].data;
            #1;
            check($sformatf("vec%0d_ill", i), {63'b0, csr_illegal}, {63'b0, vecs[i].exp_ill});
            tick();
            csr_wr_ena = 1'b0; csr_wr_op = 2'b11;
            rd_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
            $display("vec %0d op=%0d addr=%h data=%h read=%h", i, vecs[i].op, vecs[i].addr,
                     vecs[i].data, csr_rd_data);
        end

        // Random traffic against the model.
        addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                      12'hB00, 12'hB02, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0};
        idle();
        rst = 1'b1; tick(); m_reset(); rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int ri, wi;
            rst         = ($urandom_range(0, 63) == 0);
            csr_rd_ena  = 1'($urandom_range(0, 1));
            ri          = $urandom_range(0, 15);
            csr_rd_addr = (ri == 15) ? 12'($urandom) : addr_pool[ri];
            csr_wr_ena  = 1'($urandom_range(0, 1));
            wi          = $urandom_range(0, 15);
            csr_wr_addr = (wi == 15) ? 12'($urandom) : addr_pool[wi];
            csr_wr_op   = 2'($urandom_range(0, 3));
            csr_wr_data = {$urandom, $urandom};
            trap_valid  = ($urandom_range(0, 7) == 0);
            trap_cause  = {$urandom, $urandom};
            trap_pc     = {$urandom, $urandom};
            mret_valid  = ($urandom_range(0, 7) == 0);
            instret     = 1'($urandom_range(0, 1));
            timer_irq   = 1'($urandom_range(0, 1));
            #1;
            if (!(csr_rd_ena && csr_rd_addr == 12'h301 && !rst))
                check($sformatf("rnd%0d_rd", n), csr_rd_data,
                      (csr_rd_ena && !rst) ? m_read(csr_rd_addr, timer_irq) : 64'h0);
            check($sformatf("rnd%0d_ill", n), {63'b0, csr_illegal},
                  {63'b0, (csr_rd_ena && !m_impl(csr_rd_addr)) ||
                          (csr_wr_ena && !m_writable(csr_wr_addr))});
            check($sformatf("rnd%0d_irq", n), {63'b0, irq_pending},
                  {63'b0, mr[12'h300][3] & mr[12'h304][7] & timer_irq});
            check($sformatf("rnd%0d_vec", n), trap_vector, m_vector(trap_cause));
            check($sformatf("rnd%0d_mepc", n), mepc_o, mr[12'h341]);
            m_step();
            tick();
        end
        idle();
        $display("random phase: 400 cycles compared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
